// File: rtl/tv80_im2_int_ctrl.sv
// rtl/tv80_im2_int_ctrl.sv - tv80 mode-2 interrupt controller with vectored ack and ISR nesting
//
// Purpose: turns N_SRC edge-triggered peripheral requests into the active-low INT line,
//  returns the IM2 vector low byte during the M1+IORQ acknowledge cycle, and keeps an
//  in-service register so only strictly higher-priority sources (lower index) can nest.
// Optional feature macro: TV80_IM2_RETI_SNOOP_EN (snoop ED 4D opcode fetches as an EOI).
// Ports:
//  i_clk, i_reset          clock, asynchronous active-high reset
//  i_irq[N_SRC]            request lines, a rising edge raises PEND
//  o_int_n                 registered INT to the CPU, active low
//  i_m1_n/i_iorq_n/i_mreq_n/i_rd_n/i_wr_n  CPU bus strobes
//  i_addr, i_data          CPU address low byte and data bus input
//  o_data, o_data_oe       vector or register read data and its bus-mux select
// Registers at BASE_PORT+0..3: VEC, MASK (1=disabled), EOI (write only), STATUS {ISR,PEND}.
module tv80_im2_int_ctrl #(
    parameter int          N_SRC     = 4,
    parameter int          ID_W      = 2,
    parameter logic [7:0]  BASE_PORT = 8'h80
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_SRC-1:0] i_irq,
    output logic             o_int_n,
    input  logic             i_m1_n,
    input  logic             i_iorq_n,
    input  logic             i_mreq_n,
    input  logic             i_rd_n,
    input  logic             i_wr_n,
    input  logic [7:0]       i_addr,
    input  logic [7:0]       i_data,
    output logic [7:0]       o_data,
    output logic             o_data_oe
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACK, ST_SVC} state_t;

    localparam logic [7:0] VEC_BITS = 8'(8'hFF << (ID_W + 1));

    state_t             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [N_SRC-1:0]   pend_q, pend_d;
    logic [N_SRC-1:0]   isr_q, isr_d;
    logic [N_SRC-1:0]   mask_q, mask_d;
    logic [7:0]         vec_q, vec_d;
    logic [N_SRC-1:0]   irq_q, irq_d;
    logic               int_n_q, int_n_d;
    logic               wr_act_q, wr_act_d;

    logic [7:0]         off;
    logic               addr_hit, ack_cond, wr_cond, rd_cond, wr_commit, eoi_commit;
    logic               ack_take, reti_hit;
    logic [N_SRC-1:0]   irq_rise, isr_low, allowed, eligible, id_onehot;
    logic [ID_W-1:0]    winner;
    logic [15:0]        status_w;

    // Offset decode tolerates a BASE_PORT that is not 4-aligned.
    assign off       = i_addr - BASE_PORT;
    assign addr_hit  = (off[7:2] == 6'd0);
    assign ack_cond  = !i_m1_n && !i_iorq_n;
    assign wr_cond   = !i_iorq_n && !i_wr_n && i_m1_n && addr_hit;
    assign rd_cond   = !i_iorq_n && !i_rd_n && i_m1_n && addr_hit;
    // A write strobe held for several cycles commits once.
    assign wr_commit  = wr_cond && !wr_act_q;
    assign eoi_commit = wr_commit && (off[1:0] == 2'd2);
    assign ack_take   = (state_q == ST_REQ) && ack_cond;

`ifdef TV80_IM2_RETI_SNOOP_EN
    logic fetch_q, fetch_d, armed_q, armed_d, fetch_cond;

    assign fetch_cond = !i_m1_n && !i_mreq_n && !i_rd_n;

    // Each fetch is judged once, on its first cycle; ED arms, 4D right after fires.
    always_comb begin
        fetch_d  = fetch_cond;
        armed_d  = armed_q;
        reti_hit = 1'b0;
        if (fetch_cond && !fetch_q) begin
            reti_hit = armed_q && (i_data == 8'h4D);
            armed_d  = (i_data == 8'hED);
        end
    end
`else
    logic unused_mreq;
    assign unused_mreq = i_mreq_n;
    assign reti_hit    = 1'b0;
`endif

    always_comb begin
        irq_rise  = i_irq & ~irq_q;
        // Only indices below the lowest in-service bit may interrupt.
        isr_low   = isr_q & (~isr_q + N_SRC'(1));
        allowed   = (isr_q == '0) ? '1 : (isr_low - N_SRC'(1));
        eligible  = pend_q & ~mask_q & allowed;
        winner    = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (eligible[k]) winner = ID_W'(k);
        end
        id_onehot = N_SRC'(1) << id_q;

        state_d  = state_q;
        id_d     = id_q;
        int_n_d  = int_n_q;
        mask_d   = mask_q;
        vec_d    = vec_q;
        irq_d    = i_irq;
        wr_act_d = wr_cond;
        isr_d    = isr_q;

        case (state_q)
            ST_IDLE: if (eligible != '0) begin
                state_d = ST_REQ;
                id_d    = winner;
                int_n_d = 1'b0;
            end
            ST_REQ: if (ack_cond) begin
                state_d = ST_ACK;
                int_n_d = 1'b1;
            end
            ST_ACK: if (i_iorq_n) state_d = ST_SVC;
            default: state_d = ST_IDLE;
        endcase

        // A fresh edge on the acked source re-sets PEND: set wins over the ack clear.
        pend_d = (pend_q & ~(ack_take ? id_onehot : '0)) | irq_rise;

        // Clearing the highest-priority ISR bit is a no-op when ISR is empty.
        if (eoi_commit || reti_hit) isr_d = isr_q & (isr_q - N_SRC'(1));
        if (ack_take)               isr_d = isr_d | id_onehot;

        if (wr_commit && off[1:0] == 2'd0) vec_d  = i_data & VEC_BITS;
        if (wr_commit && off[1:0] == 2'd1) mask_d = i_data[N_SRC-1:0];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            id_q     <= '0;
            pend_q   <= '0;
            isr_q    <= '0;
            mask_q   <= '1;
            vec_q    <= '0;
            irq_q    <= '0;
            int_n_q  <= 1'b1;
            wr_act_q <= 1'b0;
`ifdef TV80_IM2_RETI_SNOOP_EN
            fetch_q  <= 1'b0;
            armed_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            pend_q   <= pend_d;
            isr_q    <= isr_d;
            mask_q   <= mask_d;
            vec_q    <= vec_d;
            irq_q    <= irq_d;
            int_n_q  <= int_n_d;
            wr_act_q <= wr_act_d;
`ifdef TV80_IM2_RETI_SNOOP_EN
            fetch_q  <= fetch_d;
            armed_q  <= armed_d;
`endif
        end
    end

    assign o_int_n  = int_n_q;
    assign status_w = 16'({isr_q, pend_q});

    // The vector is driven in the same cycle the ack is first seen (still in REQ).
    always_comb begin
        o_data    = 8'h00;
        o_data_oe = 1'b0;
        if (!i_reset) begin
            if ((state_q == ST_REQ || state_q == ST_ACK) && ack_cond) begin
                o_data_oe = 1'b1;
                o_data    = {vec_q[7:ID_W+1], id_q, 1'b0};
            end else if (rd_cond) begin
                o_data_oe = 1'b1;
                case (off[1:0])
                    2'd0:    o_data = vec_q;
                    2'd1:    o_data = 8'(mask_q);
                    2'd3:    o_data = status_w[7:0];
                    default: o_data = 8'h00;
                endcase
            end
        end
    end

endmodule
